alu_arbiter: RTL and testbench

- Shares the single execute-stage ALU between NREQ requesters, e.g. the integer execute path and the branch/address-generation path.
- Accepts one operation at a time over a valid/ready handshake, using round-robin priority.
- Registers the operands onto the ALU, waits the ALU latency, then captures rd/z into a response register.
- Holds the response to the granted requester until that requester handshakes it.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/alu_arbiter.sv | 110 +++++++++++
 tb/tb_alu_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, RISC-V funct3/funct7 encodings and arbiter FSM states.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } alu_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        sum  = '0;
        cand = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr} + (IW+1)'(off);
            if (sum >= (IW+1)'(N))
                sum = sum - (IW+1)'(N);
            cand = sum[IW-1:0];
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one execute-stage ALU between NREQ requesters, one operation in flight,
// round-robin accept, response held until the owning requester takes it.
module alu_arbiter #(
    parameter int XLEN    = alu_pkg::XLEN,
    parameter int NREQ    = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0][XLEN-1:0] req_rs1,
    input  logic [NREQ-1:0][XLEN-1:0] req_rs2,
    input  logic [NREQ-1:0][2:0]      req_funct3,
    input  logic [NREQ-1:0][6:0]      req_funct7,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [XLEN-1:0]           rsp_rd,
    output logic                      rsp_z,
    output logic [XLEN-1:0]           alu_rs1,
    output logic [XLEN-1:0]           alu_rs2,
    output logic [2:0]                alu_funct3,
    output logic [6:0]                alu_funct7,
    input  logic [XLEN-1:0]           alu_rd,
    input  logic                      alu_z,
    output logic                      busy
);
    import alu_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    alu_arb_state_e state, nstate;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  owner;
    logic [CW-1:0]  cnt;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gidx;
    logic            gany;
    logic            accept;
    logic            wait_done;
    logic            rsp_hs;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (gany)
    );

    // The grant is drawn only from valid requesters, so any grant in IDLE is a handshake.
    assign accept    = (state == IDLE) && gany;
    assign wait_done = (state == WAIT) && (cnt == '0);
    assign rsp_hs    = (state == RESP) && rsp_ready[owner];

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: if (accept)    nstate = WAIT;
            WAIT: if (wait_done) nstate = RESP;
            RESP: if (rsp_hs)    nstate = IDLE;
            default:             nstate = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state == IDLE)
            req_ready = gnt;
        if (state == RESP)
            rsp_valid[owner] = 1'b1;
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            cnt        <= '0;
            alu_rs1    <= '0;
            alu_rs2    <= '0;
            alu_funct3 <= '0;
            alu_funct7 <= '0;
            rsp_rd     <= '0;
            rsp_z      <= 1'b0;
        end else begin
            state <= nstate;
            if (accept) begin
                alu_rs1    <= req_rs1[gidx];
                alu_rs2    <= req_rs2[gidx];
                alu_funct3 <= req_funct3[gidx];
                alu_funct7 <= req_funct7[gidx];
                owner      <= gidx;
                cnt        <= CW'(ALU_LAT);
                ptr        <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (wait_done) begin
                rsp_rd <= alu_rd;
                rsp_z  <= alu_z;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a registered RV32 ALU model (ALU_LAT=1).
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int XLEN    = 32;
    localparam int NREQ    = 2;
    localparam int ALU_LAT = 1;

    logic                      clk;
    logic                      rst;
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ-1:0][XLEN-1:0] req_rs1;
    logic [NREQ-1:0][XLEN-1:0] req_rs2;
    logic [NREQ-1:0][2:0]      req_funct3;
    logic [NREQ-1:0][6:0]      req_funct7;
    logic [NREQ-1:0]           rsp_valid;
    logic [NREQ-1:0]           rsp_ready;
    logic [XLEN-1:0]           rsp_rd;
    logic                      rsp_z;
    logic [XLEN-1:0]           alu_rs1;
    logic [XLEN-1:0]           alu_rs2;
    logic [2:0]                alu_funct3;
    logic [6:0]                alu_funct7;
    logic [XLEN-1:0]           alu_rd;
    logic                      alu_z;
    logic                      busy;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .ALU_LAT(ALU_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rd     (rsp_rd),
        .rsp_z      (rsp_z),
        .alu_rs1    (alu_rs1),
        .alu_rs2    (alu_rs2),
        .alu_funct3 (alu_funct3),
        .alu_funct7 (alu_funct7),
        .alu_rd     (alu_rd),
        .alu_z      (alu_z),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            F3_ADD_SUB: alu_f = f7[5] ? a - b : a + b;
            F3_SLL:     alu_f = a << b[4:0];
            F3_SLT:     alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            F3_SLTU:    alu_f = (a < b) ? 32'd1 : 32'd0;
            F3_XOR:     alu_f = a ^ b;
            F3_SRL_SRA: alu_f = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            F3_OR:      alu_f = a | b;
            default:    alu_f = a & b;
        endcase
    endfunction

    // Registered ALU: result valid one edge after operands are driven.
    always @(posedge clk) begin
        alu_rd <= alu_f(alu_rs1, alu_rs2, alu_funct3, alu_funct7);
        alu_z  <= (alu_f(alu_rs1, alu_rs2, alu_funct3, alu_funct7) == 32'd0);
    end

    // Issues one op and returns the first non-zero rsp_valid snapshot; lat counts cycles after accept.
    task automatic do_op(input logic idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic [6:0] f7,
                         output logic [1:0] v, output logic [31:0] rd, output logic z,
                         output int lat);
        int g;
        @(negedge clk);
        req_rs1[idx] = a; req_rs2[idx] = b; req_funct3[idx] = f3; req_funct7[idx] = f7;
        req_valid[idx] = 1'b1;
        #1;
        g = 0;
        while (req_ready[idx] !== 1'b1 && g < 20) begin
            @(negedge clk); #1; g++;
        end
        @(negedge clk);
        req_valid[idx] = 1'b0;
        #1;
        lat = 1;
        while (rsp_valid === 2'b00 && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        if (g >= 20) lat = 99;
        v = rsp_valid; rd = rsp_rd; z = rsp_z;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = '0;
        req_rs1 = '0; req_rs2 = '0; req_funct3 = '0; req_funct7 = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: req_ready=%b rsp_valid=%b busy=%b exp 00 00 0", req_ready, rsp_valid, busy);
        end
        checks++;
        if (rsp_rd !== 32'd0 || rsp_z !== 1'b0 || alu_rs1 !== 32'd0 || alu_rs2 !== 32'd0 ||
            alu_funct3 !== 3'd0 || alu_funct7 !== 7'd0) begin
            errors++;
            $display("FAIL reset_data: rsp_rd=%0d rsp_z=%b alu_rs1=%0d alu_rs2=%0d f3=%0d f7=%0h exp all 0",
                     rsp_rd, rsp_z, alu_rs1, alu_rs2, alu_funct3, alu_funct7);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_op();
        @(negedge clk);
        rsp_ready = 2'b11;
        req_rs1[0] = 32'd20; req_rs2[0] = 32'd30; req_funct3[0] = F3_ADD_SUB; req_funct7[0] = F7_BASE;
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01 || busy !== 1'b0) begin
            errors++; $display("FAIL single_accept: req_ready=%b busy=%b exp 01 0", req_ready, busy);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++;
        if (busy !== 1'b1 || req_ready !== 2'b00 || rsp_valid !== 2'b00 ||
            alu_rs1 !== 32'd20 || alu_rs2 !== 32'd30) begin
            errors++;
            $display("FAIL single_t1: busy=%b req_ready=%b rsp_valid=%b alu_rs1=%0d alu_rs2=%0d exp 1 00 00 20 30",
                     busy, req_ready, rsp_valid, alu_rs1, alu_rs2);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL single_t2: busy=%b rsp_valid=%b exp 1 00", busy, rsp_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rd !== 32'd50 || rsp_z !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_rsp: rsp_valid=%b rd=%0d z=%b busy=%b exp 01 50 0 1", rsp_valid, rsp_rd, rsp_z, busy);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL single_done: busy=%b rsp_valid=%b exp 0 00", busy, rsp_valid);
        end
    endtask

    task automatic test_sub_zero();
        logic [1:0] v; logic [31:0] rd; logic z; int lat;
        rsp_ready = 2'b11;
        do_op(1'b1, 32'd8, 32'd3, F3_ADD_SUB, F7_ALT, v, rd, z, lat);
        checks++;
        if (v !== 2'b10 || rd !== 32'd5 || z !== 1'b0 || lat != 3) begin
            errors++; $display("FAIL sub_8_3: v=%b rd=%0d z=%b lat=%0d exp 10 5 0 3", v, rd, z, lat);
        end
        checks++;
        if (alu_funct7 !== F7_ALT || alu_funct3 !== F3_ADD_SUB) begin
            errors++; $display("FAIL sub_funct: f7=%0h f3=%0d exp 20 0", alu_funct7, alu_funct3);
        end
        do_op(1'b1, 32'd20, 32'd20, F3_ADD_SUB, F7_ALT, v, rd, z, lat);
        checks++;
        if (v !== 2'b10 || rd !== 32'd0 || z !== 1'b1 || lat != 3) begin
            errors++; $display("FAIL sub_zero: v=%b rd=%0d z=%b lat=%0d exp 10 0 1 3", v, rd, z, lat);
        end
    endtask

    task automatic test_contention();
        logic [1:0]  gnt [4];
        int          gcyc[4];
        logic [1:0]  rv  [4];
        logic [31:0] rrd [4];
        int ng, nr;
        for (int i = 0; i < 4; i++) begin gnt[i] = '0; gcyc[i] = 0; rv[i] = '0; rrd[i] = '0; end
        ng = 0; nr = 0;
        rsp_ready = 2'b11;
        @(negedge clk);
        req_rs1[0] = 32'd20; req_rs2[0] = 32'd30; req_funct3[0] = F3_AND; req_funct7[0] = F7_BASE;
        req_rs1[1] = 32'd20; req_rs2[1] = 32'd30; req_funct3[1] = F3_OR;  req_funct7[1] = F7_BASE;
        req_valid = 2'b11;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (req_ready !== 2'b00 && ng < 4) begin gnt[ng] = req_ready; gcyc[ng] = cyc; ng++; end
            if (rsp_valid !== 2'b00 && nr < 4) begin rv[nr] = rsp_valid; rrd[nr] = rsp_rd; nr++; end
            @(negedge clk);
        end
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (gnt[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10) || rv[i] !== gnt[i] ||
                rrd[i] !== ((i % 2 == 0) ? 32'd20 : 32'd30)) begin
                errors++;
                $display("FAIL contention_%0d: grant=%b rsp_valid=%b rd=%0d exp %b %b %0d", i, gnt[i], rv[i], rrd[i],
                         (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 20 : 30);
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (gcyc[i] - gcyc[i-1] != ALU_LAT + 3) begin
                errors++; $display("FAIL contention_gap_%0d: interval=%0d exp %0d", i, gcyc[i] - gcyc[i-1], ALU_LAT + 3);
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [1:0] v; logic [31:0] rd; logic z; int lat; int k;
        rsp_ready = 2'b00;
        do_op(1'b0, 32'd8, 32'd3, F3_XOR, F7_BASE, v, rd, z, lat);
        checks++;
        if (v !== 2'b01 || rd !== 32'd11 || lat != 3) begin
            errors++; $display("FAIL bp_rsp: v=%b rd=%0d lat=%0d exp 01 11 3", v, rd, lat);
        end
        req_rs1[1] = 32'd1; req_rs2[1] = 32'd2; req_funct3[1] = F3_ADD_SUB; req_funct7[1] = F7_BASE;
        req_valid = 2'b10;
        rsp_ready = 2'b10;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== 2'b01 || rsp_rd !== 32'd11 || req_ready !== 2'b00 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold_%0d: rsp_valid=%b rd=%0d req_ready=%b busy=%b exp 01 11 00 1",
                         c, rsp_valid, rsp_rd, req_ready, busy);
            end
        end
        rsp_ready = 2'b11;
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 2'b10 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL bp_release: req_ready=%b rsp_valid=%b exp 10 00", req_ready, rsp_valid);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        k = 1;
        while (rsp_valid === 2'b00 && k < 20) begin @(negedge clk); #1; k++; end
        checks++;
        if (rsp_valid !== 2'b10 || rsp_rd !== 32'd3 || k != 3) begin
            errors++; $display("FAIL bp_next: rsp_valid=%b rd=%0d lat=%0d exp 10 3 3", rsp_valid, rsp_rd, k);
        end
    endtask

    task automatic test_operand_stability();
        rsp_ready = 2'b11;
        @(negedge clk);
        req_rs1[0] = 32'd20; req_rs2[0] = 32'd30; req_funct3[0] = F3_OR; req_funct7[0] = F7_BASE;
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL stab_accept: req_ready=%b exp 01", req_ready);
        end
        @(negedge clk);
        req_rs1[0] = 32'd99;
        req_valid = 2'b00;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (alu_rs1 !== 32'd20 || alu_funct3 !== F3_OR) begin
                errors++; $display("FAIL stab_wait_%0d: alu_rs1=%0d f3=%0d exp 20 6", c, alu_rs1, alu_funct3);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rd !== 32'd30) begin
            errors++; $display("FAIL stab_rsp: rsp_valid=%b rd=%0d exp 01 30", rsp_valid, rsp_rd);
        end
    endtask

    task automatic test_abort();
        int k;
        rsp_ready = 2'b11;
        @(negedge clk);
        req_rs1[0] = 32'd1; req_rs2[0] = 32'd1; req_funct3[0] = F3_ADD_SUB; req_funct7[0] = F7_BASE;
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL abort_accept: req_ready=%b exp 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL abort_async: busy=%b rsp_valid=%b exp 0 00", busy, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
                errors++; $display("FAIL abort_quiet_%0d: rsp_valid=%b busy=%b exp 00 0", c, rsp_valid, busy);
            end
        end
        req_rs1[0] = 32'd5; req_rs2[0] = 32'd6; req_funct3[0] = F3_ADD_SUB; req_funct7[0] = F7_BASE;
        req_rs1[1] = 32'd7; req_rs2[1] = 32'd8; req_funct3[1] = F3_ADD_SUB; req_funct7[1] = F7_BASE;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL abort_ptr: req_ready=%b exp 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        k = 1;
        while (rsp_valid === 2'b00 && k < 20) begin @(negedge clk); #1; k++; end
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rd !== 32'd11 || k != 3) begin
            errors++; $display("FAIL abort_next: rsp_valid=%b rd=%0d lat=%0d exp 01 11 3", rsp_valid, rsp_rd, k);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_sub_zero();
        test_contention();
        test_backpressure();
        test_operand_stability();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, exp finished", $time);
        $fatal(1);
    end

endmodule
